// File: rtl/tdc_evfifo_pkg.sv
// tdc_evfifo_pkg: shared constants and types for the TDC event FIFO.
//   - CSR register offsets (csr_a[9:0])
//   - CTRL / STAT / HEAD_META bit positions
//   - queue entry layout {polarity, channel, timestamp} and DROPPED width
package tdc_evfifo_pkg;

  localparam logic [9:0] ADDR_CTRL      = 10'd0;
  localparam logic [9:0] ADDR_STAT      = 10'd1;
  localparam logic [9:0] ADDR_THRESH    = 10'd2;
  localparam logic [9:0] ADDR_HEAD_META = 10'd3;
  localparam logic [9:0] ADDR_HEAD_TS   = 10'd4;
  localparam logic [9:0] ADDR_POP       = 10'd5;
  localparam logic [9:0] ADDR_DROPPED   = 10'd6;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQEN_BIT  = 1;
  localparam int CTRL_CLEAR_BIT  = 2;
  localparam int CTRL_MASK_LSB   = 8;

  localparam int STAT_EMPTY_BIT  = 16;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_OVF_BIT    = 18;

  localparam int META_POL_BIT    = 3;
  localparam int META_VALID_BIT  = 31;

  localparam int ENTRY_W   = 36;
  localparam int DROPCNT_W = 16;

  typedef struct packed {
    logic        polarity;
    logic [2:0]  channel;
    logic [31:0] ts;
  } entry_t;

endpackage

// File: rtl/tdc_evfifo_mem.sv
// tdc_evfifo_mem: synchronous FIFO storage for TDC event entries.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clr          drops all entries (pointers and level to 0)
//   push, wdata  write request and entry; taken when not full, or when a
//                pop happens in the same cycle
//   pop          remove head; ignored when empty
//   head         combinational view of the oldest entry
//   level        number of stored entries (0 .. 2**depth_log2)
//   full, empty  level status
module tdc_evfifo_mem
  import tdc_evfifo_pkg::*;
#(
  parameter int depth_log2 = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic                pop,
  input  entry_t              wdata,
  output entry_t              head,
  output logic [depth_log2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2-1:0] PTR_ONE = {{(depth_log2-1){1'b0}}, 1'b1};
  localparam logic [depth_log2:0]   LVL_ONE = {{depth_log2{1'b0}}, 1'b1};

  entry_t                  mem_q [DEPTH];
  logic [depth_log2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [depth_log2:0]     level_q, level_d;
  logic                    push_eff, pop_eff;

  assign empty = (level_q == '0);
  // level never exceeds DEPTH, so its MSB alone marks full
  assign full  = level_q[depth_log2];
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_eff  = pop & ~empty & ~clr;
    // when full, a simultaneous pop frees the slot the push lands in
    push_eff = push & ~clr & (~full | pop_eff);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_eff && !pop_eff)      level_d = level_q + LVL_ONE;
      else if (pop_eff && !push_eff) level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/tdc_evfifo.sv
// tdc_evfifo: CSR-bus event FIFO between the TDC core and the CPU.
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   csr_a/we/di/do     CSR bus; block page is csr_a[13:10] == csr_addr,
//                      csr_do registered and 0 when the page is not selected
//   irq                registered level interrupt
//   ev_stb/channel/polarity/ts  event input from the TDC core
// Build option: define TDC_EVFIFO_DROPCNT_EN to implement the DROPPED
// counter; otherwise DROPPED reads 0 and writes to it are ignored.
module tdc_evfifo
  import tdc_evfifo_pkg::*;
#(
  parameter logic [3:0] csr_addr   = 4'h2,
  parameter int         depth_log2 = 5,
  parameter int         nchannels  = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  input  logic        ev_stb,
  input  logic [2:0]  ev_channel,
  input  logic        ev_polarity,
  input  logic [31:0] ev_ts
);

  localparam logic [depth_log2:0] THR_ONE = {{depth_log2{1'b0}}, 1'b1};

  logic                  enable_q, enable_d;
  logic                  irq_en_q, irq_en_d;
  logic [nchannels-1:0]  mask_q, mask_d;
  logic [depth_log2:0]   thresh_q, thresh_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           csr_do_q, csr_do_d;
  logic                  irq_q, irq_d;

  logic                  sel, wr, clear, pop_eff, ev_hit, drop, push;
  logic [9:0]            reg_a;
  logic [7:0]            mask8;
  logic [depth_log2:0]   thr_eff;
  logic [DROPCNT_W-1:0]  dropped_rd;
  entry_t                head, wdata;
  logic [depth_log2:0]   level;
  logic                  full, empty;
  logic                  unused_csr_di;

  assign unused_csr_di = ^csr_di;
  assign wdata = '{polarity: ev_polarity, channel: ev_channel, ts: ev_ts};

  tdc_evfifo_mem #(.depth_log2(depth_log2)) u_mem (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr   (clear),
    .push  (push),
    .pop   (pop_eff),
    .wdata (wdata),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    sel   = (csr_a[13:10] == csr_addr);
    reg_a = csr_a[9:0];
    wr    = sel & csr_we;
    clear = wr && (reg_a == ADDR_CTRL) && csr_di[CTRL_CLEAR_BIT];
    pop_eff = wr && (reg_a == ADDR_POP) && !empty;

    // channels at or above nchannels fall on zero mask bits
    mask8 = '0;
    mask8[nchannels-1:0] = mask_q;
    ev_hit = ev_stb & enable_q & mask8[ev_channel] & ~clear;
    drop   = ev_hit & full & ~pop_eff;
    push   = ev_hit & ~drop;

    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    mask_d     = mask_q;
    thresh_d   = thresh_q;
    overflow_d = overflow_q;
    if (wr && reg_a == ADDR_CTRL) begin
      enable_d = csr_di[CTRL_ENABLE_BIT];
      irq_en_d = csr_di[CTRL_IRQEN_BIT];
      mask_d   = csr_di[CTRL_MASK_LSB +: nchannels];
    end
    if (wr && reg_a == ADDR_THRESH) thresh_d = csr_di[depth_log2:0];
    if (wr && reg_a == ADDR_STAT && csr_di[STAT_OVF_BIT]) overflow_d = 1'b0;
    // a drop in the same cycle as the clear write keeps the flag set
    if (drop) overflow_d = 1'b1;

    thr_eff = (thresh_q == '0) ? THR_ONE : thresh_q;
    irq_d   = irq_en_q & ((level >= thr_eff) | overflow_q);

    csr_do_d = '0;
    if (sel) begin
      case (reg_a)
        ADDR_CTRL: begin
          csr_do_d[CTRL_ENABLE_BIT] = enable_q;
          csr_do_d[CTRL_IRQEN_BIT]  = irq_en_q;
          csr_do_d[CTRL_MASK_LSB +: nchannels] = mask_q;
        end
        ADDR_STAT: begin
          csr_do_d[depth_log2:0]   = level;
          csr_do_d[STAT_EMPTY_BIT] = empty;
          csr_do_d[STAT_FULL_BIT]  = full;
          csr_do_d[STAT_OVF_BIT]   = overflow_q;
        end
        ADDR_THRESH: csr_do_d[depth_log2:0] = thresh_q;
        ADDR_HEAD_META: begin
          csr_do_d[META_VALID_BIT] = ~empty;
          if (!empty) begin
            csr_do_d[2:0]          = head.channel;
            csr_do_d[META_POL_BIT] = head.polarity;
          end
        end
        ADDR_HEAD_TS: if (!empty) csr_do_d = head.ts;
        ADDR_DROPPED: csr_do_d[DROPCNT_W-1:0] = dropped_rd;
        default: csr_do_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      mask_q     <= '1;
      thresh_q   <= THR_ONE;
      overflow_q <= 1'b0;
      csr_do_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      mask_q     <= mask_d;
      thresh_q   <= thresh_d;
      overflow_q <= overflow_d;
      csr_do_q   <= csr_do_d;
      irq_q      <= irq_d;
    end
  end

`ifdef TDC_EVFIFO_DROPCNT_EN
  logic [DROPCNT_W-1:0] dropped_q, dropped_d;

  always_comb begin
    dropped_d = dropped_q;
    // a write clears the counter even if an event is dropped that cycle
    if (wr && reg_a == ADDR_DROPPED)        dropped_d = '0;
    else if (drop && dropped_q != '1)       dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) dropped_q <= '0;
    else         dropped_q <= dropped_d;
  end

  assign dropped_rd = dropped_q;
`else
  assign dropped_rd = '0;
`endif

  assign csr_do = csr_do_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_tdc_evfifo.sv
module tb_tdc_evfifo;

  localparam logic [3:0] PAGE = 4'h2;
`ifdef TDC_EVFIFO_DROPCNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        ev_stb;
  logic [2:0]  ev_channel;
  logic        ev_polarity;
  logic [31:0] ev_ts;

  tdc_evfifo dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .csr_a       (csr_a),
    .csr_we      (csr_we),
    .csr_di      (csr_di),
    .csr_do      (csr_do),
    .irq         (irq),
    .ev_stb      (ev_stb),
    .ev_channel  (ev_channel),
    .ev_polarity (ev_polarity),
    .ev_ts       (ev_ts)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_do;

  // reference model state
  logic [35:0] mq[$];
  bit          m_en, m_irqen, m_ovf;
  logic [4:0]  m_mask;
  logic [5:0]  m_thr;
  int          m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_en = 0; m_irqen = 0; m_ovf = 0;
    m_mask = 5'h1F; m_thr = 6'd1; m_drop = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] page, input logic [9:0] a);
    logic [31:0] r;
    r = '0;
    if (page != PAGE) return r;
    case (a)
      10'd0: begin r[0] = m_en; r[1] = m_irqen; r[12:8] = m_mask; end
      10'd1: begin
        r[5:0] = 6'(mq.size());
        r[16]  = (mq.size() == 0);
        r[17]  = (mq.size() == 32);
        r[18]  = m_ovf;
      end
      10'd2: r[5:0] = m_thr;
      10'd3: if (mq.size() > 0) begin
        r[31] = 1'b1; r[3] = mq[0][35]; r[2:0] = mq[0][34:32];
      end
      10'd4: if (mq.size() > 0) r = mq[0][31:0];
      10'd6: r = 32'(m_drop);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit model_irq_cond();
    int t;
    t = (m_thr == 0) ? 1 : int'(m_thr);
    return m_irqen && ((mq.size() >= t) || m_ovf);
  endfunction

  // One clock cycle: drive inputs, predict, advance the model, check.
  task automatic step(input bit ev, input logic [2:0] ch, input bit pol, input logic [31:0] ts,
                      input bit we, input logic [3:0] page, input logic [9:0] a, input logic [31:0] di);
    logic [31:0] exp_do;
    bit exp_irq, sel_w, clr, hit, wrote_drop;
    ev_stb = ev; ev_channel = ch; ev_polarity = pol; ev_ts = ts;
    csr_a = {page, a}; csr_we = we; csr_di = di;
    exp_do  = model_read(page, a);
    exp_irq = model_irq_cond();
    sel_w = we && (page == PAGE);
    clr   = sel_w && (a == 10'd0) && di[2];
    hit   = ev && m_en && (ch < 3'd5) && m_mask[ch] && !clr;
    wrote_drop = 0;
    if (sel_w) begin
      case (a)
        10'd0: begin m_en = di[0]; m_irqen = di[1]; m_mask = di[12:8]; end
        10'd1: if (di[18]) m_ovf = 0;
        10'd2: m_thr = di[5:0];
        10'd6: begin wrote_drop = 1; if (DC_EN) m_drop = 0; end
        default: ;
      endcase
    end
    if (clr) mq.delete();
    if (sel_w && a == 10'd5 && mq.size() > 0) void'(mq.pop_front());
    if (hit) begin
      if (mq.size() < 32) mq.push_back({pol, ch, ts});
      else begin
        m_ovf = 1;
        if (DC_EN && !wrote_drop && m_drop < 65535) m_drop++;
      end
    end
    @(posedge sys_clk); #1;
    chk("irq", 32'(irq), 32'(exp_irq));
    if (!we) chk("csr_do", csr_do, exp_do);
    last_do = csr_do;
    ev_stb = 0; csr_we = 0;
  endtask

  task automatic idle();                                 step(0, 0, 0, 0, 0, PAGE, 10'd1, 0); endtask
  task automatic wr(input logic [9:0] a, input logic [31:0] d); step(0, 0, 0, 0, 1, PAGE, a, d); endtask
  task automatic rd(input logic [9:0] a);                step(0, 0, 0, 0, 0, PAGE, a, 0); endtask
  task automatic ev(input logic [2:0] ch, input bit pol, input logic [31:0] ts);
    step(1, ch, pol, ts, 0, PAGE, 10'd1, 0);
  endtask

  task automatic do_reset();
    sys_rst = 1; ev_stb = 0; csr_we = 0;
    @(posedge sys_clk); #1;
    chk("rst_do", csr_do, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    sys_rst = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1; csr_a = 0; csr_we = 0; csr_di = 0;
    ev_stb = 0; ev_channel = 0; ev_polarity = 0; ev_ts = 0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    do_reset();

    // reset values
    rd(10'd1); chk("rst_stat", last_do, 32'h0001_0000);
    rd(10'd0); chk("rst_ctrl", last_do, 32'h0000_1F00);
    rd(10'd2); chk("rst_thresh", last_do, 32'h1);

    // basic enqueue / head / pop
    wr(10'd0, 32'h1F01);
    ev(3'd0, 0, 32'h10); ev(3'd2, 1, 32'h20); ev(3'd4, 0, 32'h30);
    rd(10'd1); chk("lvl3", last_do & 32'h3F, 32'd3);
    rd(10'd3); chk("meta0", last_do, 32'h8000_0000);
    rd(10'd4); chk("ts0", last_do, 32'h10);
    wr(10'd5, 0); rd(10'd3); chk("meta1", last_do, 32'h8000_000A);
    wr(10'd5, 0); wr(10'd5, 0);
    rd(10'd1); chk("empty", (last_do >> 16) & 32'h1, 32'h1);
    rd(10'd3); chk("meta_valid0", last_do >> 31, 32'h0);

    // fill, overflow, DROPPED
    for (int i = 0; i < 34; i++) ev(3'(i % 5), i[0], 32'h100 + i);
    rd(10'd1); chk("full_ovf", last_do, 32'h0006_0020);
    rd(10'd6); chk("dropped2", last_do, DC_EN ? 32'd2 : 32'd0);
    wr(10'd1, 32'h0004_0000);
    rd(10'd1); chk("ovf_clr", last_do, 32'h0002_0020);

    // push and pop together while full
    step(1, 3'd3, 1, 32'hABCD, 1, PAGE, 10'd5, 0);
    rd(10'd1); chk("full_pp", last_do & 32'h3F, 32'd32);
    for (int i = 0; i < 31; i++) wr(10'd5, 0);
    rd(10'd4); chk("tail_ts", last_do, 32'hABCD);
    rd(10'd3); chk("tail_meta", last_do, 32'h8000_000B);
    wr(10'd5, 0);

    // channel mask
    wr(10'd0, 32'h0101);
    ev(3'd1, 0, 32'h44); ev(3'd0, 0, 32'h55); ev(3'd6, 0, 32'h66);
    rd(10'd1); chk("mask_lvl", last_do & 32'h3F, 32'd1);
    rd(10'd4); chk("mask_ts", last_do, 32'h55);
    rd(10'd6); chk("mask_drop", last_do, DC_EN ? 32'd2 : 32'd0);
    wr(10'd5, 0);

    // threshold interrupt
    wr(10'd2, 32'd4); wr(10'd0, 32'h1F03);
    ev(3'd0, 0, 1); ev(3'd1, 0, 2); ev(3'd2, 0, 3);
    idle(); idle(); chk("irq_below", 32'(irq), 32'h0);
    ev(3'd3, 0, 4);
    chk("irq_lat", 32'(irq), 32'h0);
    idle(); chk("irq_thr", 32'(irq), 32'h1);
    wr(10'd5, 0); idle(); chk("irq_pop", 32'(irq), 32'h0);

    // clear with a simultaneous event
    ev(3'd0, 0, 5); ev(3'd1, 0, 6);
    rd(10'd1); chk("lvl5", last_do & 32'h3F, 32'd5);
    step(1, 3'd2, 0, 32'h77, 1, PAGE, 10'd0, 32'h1F07);
    rd(10'd1); chk("clr_stat", last_do, 32'h0001_0000);
    rd(10'd6); chk("clr_drop", last_do, DC_EN ? 32'd2 : 32'd0);
    step(0, 0, 0, 0, 0, 4'h3, 10'd1, 0); chk("unsel", last_do, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit          e_b;
      logic [2:0]  ch;
      logic [31:0] d;
      int          r, w;
      if (i == 2000) do_reset();
      e_b = ($urandom_range(0, 99) < 55);
      ch  = 3'($urandom_range(0, 7));
      r   = $urandom_range(0, 99);
      if (r < 60) begin
        step(e_b, ch, 1'($urandom), $urandom, 0,
             ($urandom_range(0, 9) == 0) ? 4'h7 : PAGE, 10'($urandom_range(0, 7)), 0);
      end else begin
        w = $urandom_range(0, 99);
        d = $urandom;
        if (w < 50)      step(e_b, ch, 1'($urandom), $urandom, 1, PAGE, 10'd5, d);
        else if (w < 68) begin
          d[0] = ($urandom_range(0, 9) != 0);
          d[2] = ($urandom_range(0, 19) == 0);
          step(e_b, ch, 1'($urandom), $urandom, 1, PAGE, 10'd0, d);
        end
        else if (w < 80) step(e_b, ch, 1'($urandom), $urandom, 1, PAGE, 10'd2, 32'($urandom_range(0, 40)));
        else if (w < 90) step(e_b, ch, 1'($urandom), $urandom, 1, PAGE, 10'd1, d);
        else if (w < 95) step(e_b, ch, 1'($urandom), $urandom, 1, PAGE, 10'd6, d);
        else             step(e_b, ch, 1'($urandom), $urandom, 1, 4'h5, 10'd0, d);
      end
    end

    // reset in the middle of activity
    wr(10'd0, 32'h1F03);
    ev(3'd0, 1, 32'h99); ev(3'd1, 1, 32'h9A);
    do_reset();
    rd(10'd1); chk("post_rst_stat", last_do, 32'h0001_0000);
    rd(10'd0); chk("post_rst_ctrl", last_do, 32'h0000_1F00);
    rd(10'd6); chk("post_rst_drop", last_do, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
